md_unit_param: RTL and testbench
================================

Name: md_unit_param

Overview:
- Parametrised multiply/divide unit for the E stage of the 5-stage pipelined CPU.
- Successor to the fixed 32-bit mult_div block. Adds configurable data width and per-class latencies, madd/msub accumulate modes, a completion pulse, and defined divide-by-zero and overflow results.
- Owns the HI/LO registers.
- The pipeline stalls D on `busy` or `start` whenever an md/mt/mf instruction is in D, and drives `cancel` from IntReq.

Parameters:
- W, 32: operand width; HI and LO are each W bits.
- MULT_CYCLES, 5: busy cycles for mult/multu/madd/maddu/msub/msubu; must be >= 1.
- DIV_CYCLES, 10: busy cycles for div/divu; must be >= 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  E-stage instruction is an MDU op this cycle.
- op  in  4  operation code:
  - 0 mult, 1 multu, 2 div, 3 divu
  - 4 madd, 5 maddu, 6 msub, 7 msubu
  - 8 mthi, 9 mtlo
  - 10-15 no-op
- rs  in  W  first operand (forwarded rs value).
- rt  in  W  second operand (forwarded rt value).
- cancel  in  1  exception/interrupt flush (IntReq); blocks acceptance of a new op.
- busy  out  1  a multi-cycle operation is in progress.
- done  out  1  one-cycle pulse in the cycle the new HI/LO first becomes visible.
- hi  out  W  HI register.
- lo  out  W  LO register.

Behaviour:
- Reset (clk edge with reset=1):
  - hi=0, lo=0, busy=0, done=0.
  - Counter cleared; any in-flight operation is discarded.
  - Reset has priority over every other input.
- Acceptance: an op is accepted at edge T iff start=1, cancel=0, busy=0 and op <= 9.
  - An op with start=1 while busy=1 is ignored; the pipeline's stall guarantees this never occurs.
  - An op with cancel=1 has no effect, including mthi/mtlo.
- mthi/mtlo: hi<=rs (or lo<=rs) at edge T. busy stays 0 and done stays 0.
- Multi-cycle ops:
  - Operands are latched at edge T.
  - busy=1 for exactly N cycles starting the cycle after T, where N = MULT_CYCLES or DIV_CYCLES.
  - At the edge ending the Nth busy cycle: hi/lo are written, busy falls to 0, and done=1 for the following cycle.
  - Total latency from the start cycle to the result being visible is N+1 cycles.
  - Back-to-back: a new start is accepted in the cycle done=1.
- cancel while busy=1 does not abort: the op was committed when it passed E.
- Arithmetic (P = full 2W-bit product):
  - mult/multu: {hi,lo} = signed/unsigned rs*rt.
  - madd/maddu: {hi,lo} = {hi,lo} + P, modulo 2^(2W).
  - msub/msubu: {hi,lo} = {hi,lo} - P, modulo 2^(2W).
  - The accumulator is the value of {hi,lo} at completion time, not at start. This value is unchanged in between because mthi/mtlo cannot be accepted while busy.
- div/divu:
  - lo = quotient, hi = remainder.
  - Signed quotient truncates toward zero; the remainder takes the dividend's sign.
- Boundary cases:
  - Divide by zero (rt=0): still busy for DIV_CYCLES, done still pulses, hi/lo keep their prior values.
  - Signed div of the most negative value by -1: lo = most negative value, hi = 0. No exception is raised.
- hi/lo never change except at acceptance of mthi/mtlo, at completion, or at reset.
- During busy, hi/lo show the old values. The stall on mf* prevents them from being read.
- Counter width: ceil(log2(max(MULT_CYCLES, DIV_CYCLES)+1)).

Test Plan:
All scenarios use W=32, MULT_CYCLES=5, DIV_CYCLES=10.
1. Signed multiply:
   - Stimulus: mult rs=0xFFFFFFFD (-3), rt=5.
   - Response: busy high for 5 cycles, then done pulse; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
   - Also run multu with the same operands: hi=0x00000004, lo=0xFFFFFFF1.
2. Signed divide:
   - Stimulus: div rs=0xFFFFFFF9 (-7), rt=2.
   - Response: busy for 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
   - Also run divu 7/0: hi/lo unchanged, done still pulses after 10 busy cycles.
   - Also run div 0x80000000 by 0xFFFFFFFF: lo=0x80000000, hi=0.
3. Accumulate:
   - Stimulus: mthi 0, mtlo 1, then madd rs=rt=0x00010000.
   - Response: hi=0x00000001, lo=0x00000001.
   - Follow with msubu using the same operands: hi=0, lo=1.
4. Cancel:
   - Stimulus: mult 2*3 with cancel=1 in the start cycle.
   - Response: busy stays 0, hi/lo unchanged.
   - Stimulus: mult 2*3 accepted, then cancel=1 in the second busy cycle.
   - Response: completes normally with lo=6.
5. Reset mid-operation: reset asserted in the third busy cycle of a div -> next cycle busy=0, hi=lo=0, and no done pulse follows.
6. Back-to-back and parameter sweep:
   - Stimulus: start a second mult in the done cycle.
   - Response: accepted, result after 5 more busy cycles.
   - Re-run scenario 1 with W=16, MULT_CYCLES=1, expecting hi=0xFFFF, lo=0xFFF1.

Source files
------------

// File: rtl/md_unit_param.sv
// Multiply/divide unit for the E stage; owns HI/LO.
// Multi-cycle ops latch operands, count down, then commit HI/LO.
module md_unit_param #(
    parameter int W           = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [3:0]   op,
    input  logic [W-1:0] rs,
    input  logic [W-1:0] rt,
    input  logic         cancel,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ?
                          MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [3:0]      r_op;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_hi;
    logic [W-1:0]    r_lo;
    logic            r_done;

    logic            w_take;
    logic            w_multi;
    logic            w_is_div;
    logic            w_fin;

    assign w_take   = start && !cancel &&
                      (r_state == S_IDLE) && (op <= 4'd9);
    assign w_multi  = w_take && (op <= 4'd7);
    assign w_is_div = (op == 4'd2) || (op == 4'd3);
    assign w_fin    = (r_state == S_BUSY) && (r_cnt == '0);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_multi) begin
                    w_state_nxt = S_BUSY;
                    w_cnt_nxt   = w_is_div ? CW'(DIV_CYCLES - 1)
                                           : CW'(MULT_CYCLES - 1);
                end
            end
            S_BUSY: begin
                if (r_cnt == '0)
                    w_state_nxt = S_IDLE;
                else
                    w_cnt_nxt = r_cnt - 1'b1;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Even opcodes are the signed variants for every multi-cycle op.
    logic            w_sgn;
    logic [2*W-1:0]  w_ax;
    logic [2*W-1:0]  w_bx;
    logic [2*W-1:0]  w_prod;
    logic [2*W-1:0]  w_hilo;

    assign w_sgn  = ~r_op[0];
    assign w_ax   = {{W{w_sgn & r_a[W-1]}}, r_a};
    assign w_bx   = {{W{w_sgn & r_b[W-1]}}, r_b};
    assign w_prod = w_ax * w_bx;
    assign w_hilo = {r_hi, r_lo};

    // Divide on magnitudes; min/-1 wraps back to min with zero remainder.
    logic            w_an;
    logic            w_bn;
    logic [W-1:0]    w_ua;
    logic [W-1:0]    w_ub;
    logic [W-1:0]    w_uq;
    logic [W-1:0]    w_ur;
    logic [W-1:0]    w_q;
    logic [W-1:0]    w_r;
    logic            w_bz;

    assign w_an = w_sgn & r_a[W-1];
    assign w_bn = w_sgn & r_b[W-1];
    assign w_ua = w_an ? -r_a : r_a;
    assign w_ub = w_bn ? -r_b : r_b;
    assign w_bz = (r_b == '0);
    assign w_uq = w_bz ? '0 : (w_ua / w_ub);
    assign w_ur = w_bz ? '0 : (w_ua % w_ub);
    assign w_q  = (w_an ^ w_bn) ? -w_uq : w_uq;
    assign w_r  = w_an ? -w_ur : w_ur;

    logic [2*W-1:0]  w_res;

    always_comb begin
        w_res = w_hilo;
        case (r_op)
            4'd0, 4'd1: w_res = w_prod;
            4'd2, 4'd3: if (!w_bz) w_res = {w_r, w_q};
            4'd4, 4'd5: w_res = w_hilo + w_prod;
            4'd6, 4'd7: w_res = w_hilo - w_prod;
            default:    w_res = w_hilo;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_fin;
            if (w_fin)
                {r_hi, r_lo} <= w_res;
            else if (w_take && (op == 4'd8))
                r_hi <= rs;
            else if (w_take && (op == 4'd9))
                r_lo <= rs;
            if (w_multi) begin
                r_op <= op;
                r_a  <= rs;
                r_b  <= rt;
            end
        end
    end

    assign busy = (r_state == S_BUSY);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_md_unit_param.sv
// Scoreboard bench for md_unit_param: expected HI/LO and busy
// length queued at issue, checked by monitors on each done pulse.
module tb_md_unit_param;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          len;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  op = '0;
    logic [31:0] rs = '0;
    logic [31:0] rt = '0;
    logic        cancel = 1'b0;
    logic        busy, done;
    logic [31:0] hi, lo;

    logic        s2_start = 1'b0;
    logic [3:0]  s2_op = '0;
    logic [15:0] s2_rs = '0;
    logic [15:0] s2_rt = '0;
    logic        s2_busy, s2_done;
    logic [15:0] s2_hi, s2_lo;

    int checks = 0;
    int failures = 0;
    int bcnt1 = 0;
    int bcnt2 = 0;
    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;

    md_unit_param #(.W(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs(rs), .rt(rt), .cancel(cancel), .busy(busy),
        .done(done), .hi(hi), .lo(lo)
    );

    md_unit_param #(.W(16), .MULT_CYCLES(1), .DIV_CYCLES(10)) dut2 (
        .clk(clk), .reset(reset), .start(s2_start), .op(s2_op),
        .rs(s2_rs), .rt(s2_rt), .cancel(1'b0), .busy(s2_busy),
        .done(s2_done), .hi(s2_hi), .lo(s2_lo)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            if (q1.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: hi=%h lo=%h", hi, lo);
            end else begin
                e = q1.pop_front();
                chk("hi", hi, e.hi);
                chk("lo", lo, e.lo);
                chk("busy_len", 32'(bcnt1), 32'(e.len));
            end
            bcnt1 = 0;
        end else if (busy === 1'b1) begin
            bcnt1++;
        end else begin
            bcnt1 = 0;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (s2_done === 1'b1) begin
            if (q2.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done_w16: hi=%h", s2_hi);
            end else begin
                e = q2.pop_front();
                chk("w16_hi", {16'h0, s2_hi}, e.hi);
                chk("w16_lo", {16'h0, s2_lo}, e.lo);
                chk("w16_busy_len", 32'(bcnt2), 32'(e.len));
            end
            bcnt2 = 0;
        end else if (s2_busy === 1'b1) begin
            bcnt2++;
        end else begin
            bcnt2 = 0;
        end
    end

    task automatic exp1(input logic [31:0] h, input logic [31:0] l,
                        input int n);
        q1.push_back('{h, l, n});
    endtask

    task automatic issue(input logic [3:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic c,
                         input bit sync);
        if (sync) @(negedge clk);
        start  = 1'b1;
        op     = o;
        rs     = a;
        rt     = b;
        cancel = c;
        @(posedge clk);
        #1;
        start  = 1'b0;
        cancel = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < 40);
        if (done !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL done_timeout: busy=%b", busy);
        end
    endtask

    task automatic run2(input logic [3:0] o, input logic [15:0] a,
                        input logic [15:0] b);
        int n = 0;
        @(negedge clk);
        s2_start = 1'b1;
        s2_op    = o;
        s2_rs    = a;
        s2_rt    = b;
        @(posedge clk);
        #1;
        s2_start = 1'b0;
        do begin
            @(negedge clk);
            n++;
        end while (s2_done !== 1'b1 && n < 20);
        if (s2_done !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL w16_timeout: busy=%b", s2_busy);
        end
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_done", {31'h0, done}, 32'h0);

        exp1(32'hFFFFFFFF, 32'hFFFFFFF1, 5);
        issue(4'd0, 32'hFFFFFFFD, 32'd5, 1'b0, 1'b1);
        wait_done();
        exp1(32'h00000004, 32'hFFFFFFF1, 5);
        issue(4'd1, 32'hFFFFFFFD, 32'd5, 1'b0, 1'b1);
        wait_done();

        exp1(32'hFFFFFFFF, 32'hFFFFFFFD, 10);
        issue(4'd2, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b1);
        wait_done();
        exp1(32'hFFFFFFFF, 32'hFFFFFFFD, 10);
        issue(4'd3, 32'd7, 32'd0, 1'b0, 1'b1);
        wait_done();
        exp1(32'h00000000, 32'h80000000, 10);
        issue(4'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b1);
        wait_done();

        issue(4'd8, 32'h0, 32'h0, 1'b0, 1'b1);
        issue(4'd9, 32'h1, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        chk("mt_hi", hi, 32'h0);
        chk("mt_lo", lo, 32'h1);
        chk("mt_busy", {31'h0, busy}, 32'h0);
        chk("mt_done", {31'h0, done}, 32'h0);
        exp1(32'h1, 32'h1, 5);
        issue(4'd4, 32'h00010000, 32'h00010000, 1'b0, 1'b1);
        wait_done();
        exp1(32'h0, 32'h1, 5);
        issue(4'd7, 32'h00010000, 32'h00010000, 1'b0, 1'b1);
        wait_done();

        issue(4'd0, 32'd2, 32'd3, 1'b1, 1'b1);
        @(negedge clk);
        chk("cancel_busy", {31'h0, busy}, 32'h0);
        issue(4'd8, 32'hDEAD, 32'h0, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        chk("cancel_hi", hi, 32'h0);
        chk("cancel_lo", lo, 32'h1);

        exp1(32'h0, 32'h6, 5);
        issue(4'd0, 32'd2, 32'd3, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        cancel = 1'b1;
        @(posedge clk);
        #1;
        cancel = 1'b0;
        wait_done();

        issue(4'd2, 32'd100, 32'd7, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_busy", {31'h0, busy}, 32'h0);
        chk("midrst_hi", hi, 32'h0);
        chk("midrst_lo", lo, 32'h0);
        repeat (15) @(negedge clk);

        exp1(32'h0, 32'h3F, 5);
        issue(4'd0, 32'd7, 32'd9, 1'b0, 1'b1);
        wait_done();
        exp1(32'h0, 32'h1, 5);
        issue(4'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
        wait_done();

        q2.push_back('{32'h0000FFFF, 32'h0000FFF1, 1});
        run2(4'd0, 16'hFFFD, 16'd5);
        q2.push_back('{32'h00000004, 32'h0000FFF1, 1});
        run2(4'd1, 16'hFFFD, 16'd5);

        repeat (3) @(negedge clk);
        chk("queues_drained", 32'(q1.size() + q2.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
